mult_sequencer: RTL and testbench



---
 rtl/mult_sequencer_pkg.sv | 15 +
 rtl/mult_sequencer_if.sv | 24 ++
 rtl/mult_sequencer_adder.sv | 15 +
 rtl/mult_sequencer.sv | 150 +++++++++++++++
 tb/tb_mult_sequencer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared types and sizing constants for the shift-add multiplier sequencer.
// Operand width, iteration count and the controller state encoding.
package mult_pkg;

  localparam int MULT_W     = 16;
  localparam int MULT_CNT_W = 4;
  localparam int MULT_ITER  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Start/busy/done handshake between the control unit and the multiplier.
// The master is the control unit; the slave is the sequencer.
interface mult_sequencer_if;
  import mult_pkg::*;

  logic                  start;
  logic [MULT_W-1:0]     a;
  logic [MULT_W-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [2*MULT_W-1:0]   product;
  logic                  overflow;

  modport master (
    output start, a, b,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, overflow
  );

endinterface

// File: rtl/mult_sequencer_adder.sv
// Shared 16-bit adder used once per iteration by the multiplier sequencer.
// C14 is the carry into bit 15, recovered from the top sum bit.
module _16_bit_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CIn,
  output logic [15:0] S,
  output logic        COut,
  output logic        C14
);

  assign {COut, S} = {1'b0, A} + {1'b0, B} + {16'd0, CIn};
  assign C14       = A[15] ^ B[15] ^ S[15];

endmodule

// File: rtl/mult_sequencer.sv
// Unsigned 16x16->32 shift-add multiplier: sequences one shared adder over
// exactly 16 iterations and holds the result until the next accepted start.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_sequencer_if.slave   bus
);

  localparam logic [MULT_CNT_W-1:0] CNT_LAST = MULT_CNT_W'(MULT_ITER - 1);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [MULT_CNT_W-1:0]  count_r;
  logic [WIDTH-1:0]       m_r;
  logic [WIDTH-1:0]       q_r;
  logic [WIDTH-1:0]       p_r;
  logic                   c_r;

  logic [WIDTH-1:0]       add_b_s;
  logic [WIDTH-1:0]       sum_s;
  logic                   cout_s;
  logic                   c14_unused;
  logic [2*WIDTH:0]       shifted_s;
  logic                   c_next_s;
  logic [WIDTH-1:0]       p_next_s;
  logic [WIDTH-1:0]       q_next_s;
  logic                   accept_s;
  logic                   last_s;
  logic                   busy_s;
  logic                   done_s;

  logic                   busy_r;
  logic                   done_r;
  logic [2*WIDTH-1:0]     product_r;
  logic                   overflow_r;

  assign accept_s = (state_r == IDLE) && bus.start;
  assign last_s   = (state_r == RUN) && (count_r == CNT_LAST);
  assign add_b_s  = q_r[0] ? m_r : {WIDTH{1'b0}};

  _16_bit_adder u_adder (
    .A    (p_r),
    .B    (add_b_s),
    .CIn  (1'b0),
    .S    (sum_s),
    .COut (cout_s),
    .C14  (c14_unused)
  );

  // The adder carry lands in P[15] once the whole {C,P,Q} word shifts right.
  always_comb begin
    shifted_s = {cout_s, sum_s, q_r} >> 1;
    c_next_s  = shifted_s[2*WIDTH];
    p_next_s  = shifted_s[2*WIDTH-1:WIDTH];
    q_next_s  = shifted_s[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = RUN;
        else           state_next_s = IDLE;
      end
      RUN: begin
        if (count_r == CNT_LAST) state_next_s = DONE;
        else                     state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done leave flops directly.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_next_s)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture, per-iteration shift and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r     <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      p_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      count_r <= {MULT_CNT_W{1'b0}};
    end else if (accept_s) begin
      m_r     <= bus.a;
      q_r     <= bus.b;
      p_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      count_r <= {MULT_CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      p_r     <= p_next_s;
      q_r     <= q_next_s;
      c_r     <= c_next_s;
      count_r <= count_r + {{(MULT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Registered handshake outputs and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      product_r  <= {(2*WIDTH){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if (last_s) begin
        product_r  <= {p_next_s, q_next_s};
        overflow_r <= |p_next_s;
      end else begin
        product_r  <= product_r;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.product  = product_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: scoreboard of expected products checked
// on every done pulse, plus cycle-accurate busy/done/hold checks.
module tb_mult_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [32:0] exp_q[$];
  logic [31:0] held;

  mult_sequencer_if mif ();

  mult_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mif.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("product", {32'd0, mif.product}, {32'd0, e[31:0]});
        chk("overflow", {63'd0, mif.overflow}, {63'd0, e[32]});
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit inject);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = a;
    mif.b     = b;
    exp_q.push_back({(p[31:16] != 16'd0), p});
    @(posedge clk);
    #1 mif.start = 1'b0;
    mif.a = 16'hDEAD;
    mif.b = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("busy_run", {63'd0, mif.busy}, 64'd1);
      chk("done_run", {63'd0, mif.done}, 64'd0);
      chk("hold", {32'd0, mif.product}, {32'd0, held});
      if (inject && i == 5) begin
        mif.start = 1'b1;
        mif.a     = 16'hFFFF;
        mif.b     = 16'hFFFF;
      end else begin
        mif.start = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_pulse", {63'd0, mif.done}, 64'd1);
    chk("busy_in_done", {63'd0, mif.busy}, 64'd0);
    if (inject) begin
      mif.start = 1'b1;
      mif.a     = 16'hFFFF;
    end
    held = p;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
    chk("done_single", {63'd0, mif.done}, 64'd0);
    chk("busy_idle", {63'd0, mif.busy}, 64'd0);
    chk("product_held", {32'd0, mif.product}, {32'd0, p});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    held      = 32'd0;
    mif.start = 1'b0;
    mif.a     = 16'd0;
    mif.b     = 16'd0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, mif.busy}, 64'd0);
    chk("rst_done", {63'd0, mif.done}, 64'd0);
    chk("rst_product", {32'd0, mif.product}, 64'd0);
    chk("rst_overflow", {63'd0, mif.overflow}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd3, 16'd5, 1'b0);
    chk("basic_const", {32'd0, mif.product}, 64'h0000_000F);
    run_op(16'h00FF, 16'h0100, 1'b0);
    chk("hold_const", {32'd0, mif.product}, 64'h0000_FF00);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    chk("full_const", {32'd0, mif.product}, 64'hFFFE_0001);
    chk("full_ovf", {63'd0, mif.overflow}, 64'd1);
    run_op(16'h0000, 16'h1234, 1'b0);
    run_op(16'h8000, 16'h0002, 1'b0);
    chk("boundary_const", {32'd0, mif.product}, 64'h0001_0000);
    run_op(16'd7, 16'd9, 1'b1);
    chk("ignored_const", {32'd0, mif.product}, 64'h0000_003F);

    // Reset in the middle of a RUN: outputs clear at once, no done follows.
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = 16'h1234;
    mif.b     = 16'h5678;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {63'd0, mif.busy}, 64'd0);
    chk("async_done", {63'd0, mif.done}, 64'd0);
    chk("async_product", {32'd0, mif.product}, 64'd0);
    chk("async_overflow", {63'd0, mif.overflow}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", {63'd0, mif.done}, 64'd0);
    end
    rst_n = 1'b1;
    held  = 32'd0;
    repeat (20) begin
      @(negedge clk);
      chk("no_abort_done", {63'd0, mif.done}, 64'd0);
    end

    run_op(16'd2, 16'd3, 1'b0);
    chk("post_reset_const", {32'd0, mif.product}, 64'd6);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
